// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with one outstanding bus access, load extraction and a bus timeout.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of performing them.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ALU_result,
  input  logic [31:0] StoreData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        RegWrite,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,
  output logic [31:0] wb_result,
  output logic        stall,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  // Handshake: an instruction is taken on an edge with in_valid & in_ready; there is no
  // downstream backpressure, out_valid is a one-cycle pulse per completed instruction.
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q, mem_we_q, out_valid_q, out_regwrite_q, bus_err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, wb_result_q;
  logic [3:0]  mem_wstrb_q;
  logic [4:0]  out_rd_q, rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        store_q, regwrite_q;

  logic        is_mem;
  logic [3:0]  st_strb_d;
  logic [31:0] st_data_d, ld_data_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_mem   = MemRead | MemWrite;
  assign in_ready = (state_q == IDLE);
  assign stall    = (state_q == BUSY) | (in_valid & is_mem & (state_q == IDLE));

  // funct3[1:0] gives the access size for both loads and stores: 00 byte, 01 half, else word.
  always_comb begin
    st_strb_d = 4'b1111;
    st_data_d = StoreData;
    case (funct3[1:0])
      2'b00: begin
        st_strb_d = 4'b0001 << ALU_result[1:0];
        st_data_d = {4{StoreData[7:0]}};
      end
      2'b01: begin
        st_strb_d = ALU_result[1] ? 4'b1100 : 4'b0011;
        st_data_d = {2{StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lo_q)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ;
    endcase
    ld_half   = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data_d = mem_rdata;
    case (f3_q)
      3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data_d = {24'b0, ld_byte};
      3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data_d = {16'b0, ld_half};
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  logic misaligned;
  assign misaligned = ((funct3[1:0] == 2'b01) & ALU_result[0]) |
                      (funct3[1] & (ALU_result[1:0] != 2'b00));
  assign misalign   = misalign_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wstrb_q    <= '0;
      mem_wdata_q    <= '0;
      out_valid_q    <= 1'b0;
      out_rd_q       <= '0;
      out_regwrite_q <= 1'b0;
      wb_result_q    <= '0;
      bus_err_q      <= 1'b0;
      rd_q           <= '0;
      f3_q           <= '0;
      lo_q           <= '0;
      store_q        <= 1'b0;
      regwrite_q     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q     <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              out_valid_q    <= 1'b1;
              out_rd_q       <= rd;
              out_regwrite_q <= RegWrite;
              wb_result_q    <= ALU_result;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            else if (misaligned) begin
              out_valid_q    <= 1'b1;
              out_rd_q       <= rd;
              out_regwrite_q <= 1'b0;
              misalign_q     <= 1'b1;
            end
`endif
            else begin
              state_q     <= BUSY;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= MemWrite;
              mem_addr_q  <= {ALU_result[31:2], 2'b00};
              mem_wstrb_q <= MemWrite ? st_strb_d : 4'b0000;
              mem_wdata_q <= MemWrite ? st_data_d : 32'h0;
              rd_q        <= rd;
              f3_q        <= funct3;
              lo_q        <= ALU_result[1:0];
              store_q     <= MemWrite;
              regwrite_q  <= RegWrite;
            end
          end
        end
        BUSY: begin
          // An ack on the last counted cycle wins over the timeout.
          if (mem_ack) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_wstrb_q    <= 4'b0000;
            out_valid_q    <= 1'b1;
            out_rd_q       <= rd_q;
            out_regwrite_q <= regwrite_q & ~store_q;
            if (!store_q) wb_result_q <= ld_data_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_wstrb_q    <= 4'b0000;
            out_valid_q    <= 1'b1;
            out_rd_q       <= rd_q;
            out_regwrite_q <= 1'b0;
            bus_err_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign mem_wdata    = mem_wdata_q;
  assign out_valid    = out_valid_q;
  assign out_rd       = out_rd_q;
  assign out_regwrite = out_regwrite_q;
  assign wb_result    = wb_result_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a behavioural model.
// Honours MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0;
  logic [31:0] ALU_result = '0, StoreData = '0, mem_rdata = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        mem_ack = 1'b0;
  logic        in_ready, mem_req, mem_we, out_valid, out_regwrite, stall, bus_err;
  logic [31:0] mem_addr, mem_wdata, wb_result;
  logic [3:0]  mem_wstrb;
  logic [4:0]  out_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_vec = 0, n_miss = 0;

  // results of the last run_mem transaction
  int          r_req, r_err;
  logic        r_stall, r_stable, r_we, r_valid, r_rw;
  logic [31:0] r_addr, r_wdata, r_wb;
  logic [3:0]  r_strb;
  logic [4:0]  r_rd;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_result(ALU_result), .StoreData(StoreData), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .rd(rd), .RegWrite(RegWrite), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .out_valid(out_valid), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .wb_result(wb_result), .stall(stall), .bus_err(bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // reference model
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    int off;
    off = int'(a[1:0]);
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input logic is_st, input logic [2:0] f3, input logic [31:0] a);
    int off;
    off = int'(a[1:0]);
    if (!is_st) return 4'h0;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] rand_addr(input logic [2:0] f3);
    logic [31:0] a;
    a = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01) a[0] = 1'b0;
    else if (f3[1]) a[1:0] = 2'b00;
`else
    if (f3 == 3'd7) a = 32'h0;
`endif
    return a;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    funct3 = '0; ALU_result = '0; StoreData = '0; rd = '0;
  endtask

  task automatic run_mem(input logic wr, input logic rdn, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_at,
                         input logic [4:0] rdi, input logic rw);
    in_valid = 1'b1; MemRead = rdn; MemWrite = wr; funct3 = f3; ALU_result = addr;
    StoreData = sdata; rd = rdi; RegWrite = rw;
    #1;
    r_stall = stall;
    step();
    idle_inputs();
    r_addr = mem_addr; r_wdata = mem_wdata; r_strb = mem_wstrb; r_we = mem_we;
    r_req = 0; r_err = 0; r_stable = 1'b1; r_valid = 1'b0; r_rw = 1'b0; r_rd = '0; r_wb = '0;
    for (int k = 0; k < TO + 4 && !r_valid; k++) begin
      if (mem_req) begin
        r_req++;
        r_stall = r_stall & stall;
        if ({mem_addr, mem_wdata, mem_wstrb, mem_we} !== {r_addr, r_wdata, r_strb, r_we})
          r_stable = 1'b0;
      end
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rdata : $urandom;
      step();
      mem_ack = 1'b0;
      if (bus_err) r_err++;
      if (out_valid) begin
        r_valid = 1'b1; r_rw = out_regwrite; r_rd = out_rd; r_wb = wb_result;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    repeat (3) step();
    n_vec++;
    if ({mem_req, mem_we, mem_wstrb, out_valid, out_regwrite, bus_err, stall} !== 10'b0) begin
      n_miss++;
      $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, mem_wstrb, out_valid, out_regwrite, bus_err, stall});
    end
    n_vec++;
    if ({mem_addr, mem_wdata, wb_result, out_rd, in_ready} !== {101'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL reset_data: addr %h wdata %h wb %h rd %0d in_ready %b", mem_addr, mem_wdata, wb_result, out_rd, in_ready);
    end
    mem_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    in_valid = 1'b1; rd = 5'd5; ALU_result = 32'h1234; RegWrite = 1'b1;
    #1;
    n_vec++;
    if ({stall, in_ready} !== 2'b01) begin
      n_miss++; $display("FAIL alu_stall: got stall/in_ready %b want 01", {stall, in_ready});
    end
    step();
    idle_inputs();
    n_vec++;
    if ({out_valid, out_regwrite, out_rd, wb_result, mem_req} !== {1'b1, 1'b1, 5'd5, 32'h1234, 1'b0}) begin
      n_miss++;
      $display("FAIL alu_result: valid %b rw %b rd %0d wb %h req %b want 1 1 5 00001234 0",
               out_valid, out_regwrite, out_rd, wb_result, mem_req);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_miss++; $display("FAIL alu_pulse: out_valid %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp_q[$];
    logic [37:0] exp;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; ALU_result = $urandom; rd = 5'($urandom_range(0, 31));
      RegWrite = 1'($urandom_range(0, 1));
      exp_q.push_back({RegWrite, rd, ALU_result});
      step();
      exp = exp_q.pop_front();
      n_vec++;
      if ({out_valid, out_regwrite, out_rd, wb_result} !== {1'b1, exp}) begin
        n_miss++;
        $display("FAIL b2b_%0d: got %b_%h want 1_%h", i, out_valid, {out_regwrite, out_rd, wb_result}, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_load_lb();
    run_mem(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 2, 5'd7, 1'b1);
    n_vec++;
    if ({r_addr, r_strb, r_we} !== {32'h100, 4'h0, 1'b0}) begin
      n_miss++; $display("FAIL lb_bus: addr %h strb %b we %b want 00000100 0000 0", r_addr, r_strb, r_we);
    end
    n_vec++;
    if ({r_valid, r_rw, r_rd, r_wb} !== {1'b1, 1'b1, 5'd7, 32'hFFFF_FF80}) begin
      n_miss++; $display("FAIL lb_result: valid %b rw %b rd %0d wb %h want 1 1 7 ffffff80", r_valid, r_rw, r_rd, r_wb);
    end
    n_vec++;
    if ({r_stall, r_stable, 32'(r_req), mem_req} !== {1'b1, 1'b1, 32'd3, 1'b0}) begin
      n_miss++; $display("FAIL lb_timing: stall %b stable %b req_cycles %0d req_after %b want 1 1 3 0", r_stall, r_stable, r_req, mem_req);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_miss++; $display("FAIL lb_pulse: out_valid %b want 0", out_valid);
    end
  endtask

  task automatic test_store_sh();
    run_mem(1'b1, 1'b0, 3'b001, 32'h202, 32'h5555_ABCD, 32'h0, 0, 5'd2, 1'b1);
    n_vec++;
    if ({r_addr, r_strb, r_wdata, r_we} !== {32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1}) begin
      n_miss++; $display("FAIL sh_bus: addr %h strb %b wdata %h we %b want 00000200 1100 abcdabcd 1", r_addr, r_strb, r_wdata, r_we);
    end
    n_vec++;
    if ({r_valid, r_rw, 32'(r_req)} !== {1'b1, 1'b0, 32'd1}) begin
      n_miss++; $display("FAIL sh_done: valid %b rw %b req_cycles %0d want 1 0 1", r_valid, r_rw, r_req);
    end
  endtask

  task automatic test_timeout();
    run_mem(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1000, 5'd4, 1'b1);
    n_vec++;
    if ({32'(r_req), 32'(r_err), r_valid, r_rw, mem_req} !== {32'd4, 32'd1, 1'b1, 1'b0, 1'b0}) begin
      n_miss++; $display("FAIL timeout: req_cycles %0d bus_err %0d valid %b rw %b req_after %b want 4 1 1 0 0", r_req, r_err, r_valid, r_rw, mem_req);
    end
    step();
    n_vec++;
    if ({bus_err, out_valid} !== 2'b00) begin
      n_miss++; $display("FAIL timeout_pulse: bus_err/out_valid %b want 00", {bus_err, out_valid});
    end
    // ack on the timeout cycle completes normally
    run_mem(1'b0, 1'b1, 3'b010, 32'h44, 32'h0, 32'h1357_9BDF, TO - 1, 5'd6, 1'b1);
    n_vec++;
    if ({32'(r_req), 32'(r_err), r_valid, r_rw, r_wb} !== {32'd4, 32'd0, 1'b1, 1'b1, 32'h1357_9BDF}) begin
      n_miss++; $display("FAIL ack_on_timeout: req_cycles %0d bus_err %0d valid %b rw %b wb %h want 4 0 1 1 13579bdf", r_req, r_err, r_valid, r_rw, r_wb);
    end
  endtask

  task automatic test_reset_busy();
    int seen;
    in_valid = 1'b1; MemRead = 1'b1; funct3 = 3'b010; ALU_result = 32'h80; rd = 5'd3; RegWrite = 1'b1;
    step();
    idle_inputs();
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_miss++; $display("FAIL rstb_req: mem_req %b want 1", mem_req);
    end
    #2;
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    n_vec++;
    if ({mem_req, in_ready, out_valid} !== 3'b010) begin
      n_miss++; $display("FAIL rstb_async: req/in_ready/valid %b want 010", {mem_req, in_ready, out_valid});
    end
    step(); step();
    @(negedge clk); rst_n = 1'b1; mem_ack = 1'b0;
    seen = 0;
    repeat (TO + 3) begin
      step();
      if (out_valid || bus_err || mem_req) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_miss++; $display("FAIL rstb_quiet: %0d active cycles after reset want 0", seen);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    in_valid = 1'b1; MemRead = 1'b1; funct3 = 3'b010; ALU_result = 32'h6; rd = 5'd9; RegWrite = 1'b1;
    step();
    idle_inputs();
    n_vec++;
    if ({out_valid, out_regwrite, misalign, mem_req, in_ready, out_rd} !== {5'b10101, 5'd9}) begin
      n_miss++; $display("FAIL misalign_lw: valid/rw/mis/req/rdy %b rd %0d want 10101 9", {out_valid, out_regwrite, misalign, mem_req, in_ready}, out_rd);
    end
    step();
    n_vec++;
    if ({misalign, out_valid, mem_req} !== 3'b000) begin
      n_miss++; $display("FAIL misalign_pulse: %b want 000", {misalign, out_valid, mem_req});
    end
`else
    run_mem(1'b0, 1'b1, 3'b010, 32'h6, 32'h0, 32'h1122_3344, 1, 5'd9, 1'b1);
    n_vec++;
    if ({r_addr, r_strb, r_wb, r_rw} !== {32'h4, 4'h0, 32'h1122_3344, 1'b1}) begin
      n_miss++; $display("FAIL unaligned_lw: addr %h strb %b wb %h rw %b want 00000004 0000 11223344 1", r_addr, r_strb, r_wb, r_rw);
    end
    run_mem(1'b0, 1'b1, 3'b001, 32'h3, 32'h0, 32'h8001_7FFF, 0, 5'd9, 1'b1);
    n_vec++;
    if ({r_addr, r_wb} !== {32'h0, 32'hFFFF_8001}) begin
      n_miss++; $display("FAIL unaligned_lh: addr %h wb %h want 00000000 ffff8001", r_addr, r_wb);
    end
    run_mem(1'b1, 1'b0, 3'b001, 32'h1, 32'h0000_BEEF, 32'h0, 0, 5'd0, 1'b0);
    n_vec++;
    if ({r_strb, r_wdata} !== {4'b0011, 32'hBEEF_BEEF}) begin
      n_miss++; $display("FAIL unaligned_sh: strb %b wdata %h want 0011 beefbeef", r_strb, r_wdata);
    end
`endif
  endtask

  task automatic test_random();
    logic [2:0]  ld_codes [5];
    logic [2:0]  f3;
    logic [31:0] a, sd, rdat;
    logic [4:0]  rdi;
    logic        wr, rdn, rw, tmo;
    int          kind, ack_at, exp_req;
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      rdi = 5'($urandom_range(0, 31)); rw = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        in_valid = 1'b1; ALU_result = $urandom; rd = rdi; RegWrite = rw;
        a = ALU_result;
        step();
        idle_inputs();
        n_vec++;
        if ({out_valid, out_regwrite, out_rd, wb_result, mem_req} !== {1'b1, rw, rdi, a, 1'b0}) begin
          n_miss++; $display("FAIL rnd_alu_%0d: got %b_%b_%0d_%h_%b want 1_%b_%0d_%h_0", i, out_valid, out_regwrite, out_rd, wb_result, mem_req, rw, rdi, a);
        end
      end else begin
        wr  = (kind != 1);
        rdn = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        f3  = wr ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
        a = rand_addr(f3); sd = $urandom; rdat = $urandom;
        ack_at = $urandom_range(0, TO + 1);
        tmo = (ack_at >= TO);
        exp_req = tmo ? TO : ack_at + 1;
        run_mem(wr, rdn, f3, a, sd, rdat, ack_at, rdi, rw);
        n_vec++;
        if ({r_addr, r_strb, r_we} !== {a & ~32'h3, exp_strb(wr, f3, a), wr}) begin
          n_miss++; $display("FAIL rnd_bus_%0d: addr %h strb %b we %b want %h %b %b", i, r_addr, r_strb, r_we, a & ~32'h3, exp_strb(wr, f3, a), wr);
        end
        if (wr) begin
          n_vec++;
          if (r_wdata !== exp_wdata(f3, sd)) begin
            n_miss++; $display("FAIL rnd_wdata_%0d: got %h want %h", i, r_wdata, exp_wdata(f3, sd));
          end
        end
        n_vec++;
        if ({32'(r_req), 32'(r_err), r_valid, r_stable, r_stall, r_rd, r_rw} !==
            {32'(exp_req), 32'(tmo ? 1 : 0), 1'b1, 1'b1, 1'b1, rdi, rw & ~wr & ~tmo}) begin
          n_miss++; $display("FAIL rnd_ctrl_%0d: req %0d err %0d valid %b stable %b stall %b rd %0d rw %b want %0d %0d 1 1 1 %0d %b",
                             i, r_req, r_err, r_valid, r_stable, r_stall, r_rd, r_rw, exp_req, tmo, rdi, rw & ~wr & ~tmo);
        end
        if (!wr && !tmo) begin
          n_vec++;
          if (r_wb !== exp_load(f3, a, rdat)) begin
            n_miss++; $display("FAIL rnd_load_%0d: f3 %0d addr %h data %h got %h want %h", i, f3, a, rdat, r_wb, exp_load(f3, a, rdat));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_lb();
    test_store_sh();
    test_timeout();
    test_reset_busy();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
